// File: rtl/sexy_grid_pkg.sv
//------------------------------------------------------------------------------
// sexy_grid_pkg : shared types and constants for the grid lane array.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sexy_grid_pkg;

   localparam int BYTE_W = 8;

   // Rotate feedback taps: bit 0 and the MSB (WIDTH - HI_OFS).
   localparam int ROT_FEEDBACK_TAP_LO     = 0;
   localparam int ROT_FEEDBACK_TAP_HI_OFS = 1;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      ROTL  = 2'd2,
      MIX   = 2'd3
   } lane_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/sexy_grid_lane.sv
//------------------------------------------------------------------------------
// sexy_grid_lane : one WIDTH-bit activity register with a selectable update mode.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sexy_grid_lane
   import sexy_grid_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IDX   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              load,
   input  lane_mode_e        mode,
   input  logic [BYTE_W-1:0] seed,
   output logic [WIDTH-1:0]  q
);

   lane_mode_e       mode_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             fb;

   assign fb = q_q[WIDTH-ROT_FEEDBACK_TAP_HI_OFS] ^ q_q[ROT_FEEDBACK_TAP_LO];

   // A load on this lane wins over a step in the same cycle.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = {(WIDTH/BYTE_W){seed}};
      end else if (run) begin
         case (mode_q)
            HOLD:    q_d = q_q;
            COUNT:   q_d = q_q + WIDTH'(IDX + 1);
            ROTL:    q_d = {q_q[WIDTH-2:0], fb};
            MIX:     q_d = q_q ^ {q_q[WIDTH-2:0], 1'b1};
            default: q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= WIDTH'(IDX);
         mode_q <= COUNT;
      end else begin
         q_q <= q_d;
         if (load) begin
            mode_q <= mode;
         end
      end
   end

   assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/sexy_grid_lane_array.sv
//------------------------------------------------------------------------------
// sexy_grid_lane_array : N_LANES activity lanes with a byte-serial readout port.
// Optional signature output enabled by macro SEXY_GRID_SIGNATURE_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sexy_grid_lane_array
   import sexy_grid_pkg::*;
#(
   parameter int N_LANES = 4,
   parameter int WIDTH   = 16,
   parameter int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              cfg_we,
   input  logic [LANE_W-1:0] cfg_lane,
   input  logic [1:0]        cfg_mode,
   input  logic [7:0]        cfg_seed,
   input  logic              rd_req,
   input  logic [LANE_W-1:0] rd_lane,
   input  logic              rd_ready,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic              busy
`ifdef SEXY_GRID_SIGNATURE_EN
   ,
   output logic [WIDTH-1:0]  sig
`endif
);

   localparam int N_BYTES = WIDTH / BYTE_W;
   localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   logic [WIDTH-1:0]   lane_q [N_LANES];
   logic [N_LANES-1:0] lane_load;
   logic [WIDTH-1:0]   rd_sel;

   rd_state_e          state_q;
   logic [WIDTH-1:0]   snap_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic [BYTE_W-1:0]  rd_data_q;
   logic               rd_valid_q;
   logic               rd_last_q;

   // Out-of-range lane indices match no lane, so writes drop and reads give 0.
   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         assign lane_load[gi] = cfg_we && (cfg_lane == LANE_W'(gi));

         sexy_grid_lane #(
            .WIDTH (WIDTH),
            .IDX   (gi)
         ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .run  (run),
            .load (lane_load[gi]),
            .mode (lane_mode_e'(cfg_mode)),
            .seed (cfg_seed),
            .q    (lane_q[gi])
         );
      end
   endgenerate

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < N_LANES; i++) begin
         if (rd_lane == LANE_W'(i)) begin
            rd_sel = lane_q[i];
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_req) begin
                  state_q    <= SEND;
                  snap_q     <= rd_sel;
                  cnt_q      <= '0;
                  rd_data_q  <= rd_sel[BYTE_W-1:0];
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (N_BYTES == 1);
               end
            end
            SEND: begin
               if (rd_ready) begin
                  if (cnt_q == CNT_W'(N_BYTES - 1)) begin
                     state_q    <= IDLE;
                     cnt_q      <= '0;
                     rd_data_q  <= '0;
                     rd_valid_q <= 1'b0;
                     rd_last_q  <= 1'b0;
                  end else begin
                     cnt_q     <= cnt_inc;
                     rd_data_q <= snap_q[int'(cnt_inc)*BYTE_W +: BYTE_W];
                     rd_last_q <= (cnt_inc == CNT_W'(N_BYTES - 1));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign busy     = (state_q != IDLE);

`ifdef SEXY_GRID_SIGNATURE_EN
   logic [WIDTH-1:0] lane_xor;
   logic [WIDTH-1:0] sig_q;

   always_comb begin
      lane_xor = '0;
      for (int i = 0; i < N_LANES; i++) begin
         lane_xor = lane_xor ^ lane_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else if (run) begin
         sig_q <= {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ lane_xor;
      end
   end

   assign sig = sig_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sexy_grid_lane_array.sv
//------------------------------------------------------------------------------
// tb_sexy_grid_lane_array : vector table plus byte scoreboard for the lane array.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sexy_grid_lane_array;

   logic       clk;
   logic       rst;
   logic       run;
   logic       cfg_we;
   logic [1:0] cfg_lane;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_seed;
   logic       rd_req;
   logic [1:0] rd_lane;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_last;
   logic       busy;
`ifdef SEXY_GRID_SIGNATURE_EN
   logic [15:0] sig;
`endif

   sexy_grid_lane_array #(
      .N_LANES (4),
      .WIDTH   (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .cfg_we   (cfg_we),
      .cfg_lane (cfg_lane),
      .cfg_mode (cfg_mode),
      .cfg_seed (cfg_seed),
      .rd_req   (rd_req),
      .rd_lane  (rd_lane),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_last  (rd_last),
      .busy     (busy)
`ifdef SEXY_GRID_SIGNATURE_EN
      ,
      .sig      (sig)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } byte_t;

   typedef struct {
      logic       we;
      logic [1:0] lane;
      logic [1:0] mode;
      logic [7:0] seed;
      int         nrun;
      logic [1:0] rd;
      logic [15:0] exp;
   } vec_t;

   byte_t exp_q[$];
   vec_t  vt[12];
   int    n_cmp  = 0;
   int    n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: a byte is consumed on the edge following a valid&ready sample.
   always @(negedge clk) begin
      if (rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, rd_data}, 32'hFFFF_FFFF);
         end else begin
            byte_t e;
            e = exp_q.pop_front();
            check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
            check("rd_last", {31'd0, rd_last}, {31'd0, e.last});
         end
      end
   end

   task automatic cycle(input logic r, input logic we, input logic [1:0] ln,
                        input logic [1:0] md, input logic [7:0] sd);
      run      = r;
      cfg_we   = we;
      cfg_lane = ln;
      cfg_mode = md;
      cfg_seed = sd;
      @(posedge clk);
      #1;
      run    = 1'b0;
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic start_read(input logic [1:0] ln, input logic [15:0] exp, input logic push);
      if (push) begin
         exp_q.push_back('{exp[7:0], 1'b0});
         exp_q.push_back('{exp[15:8], 1'b1});
      end
      rd_lane = ln;
      rd_req  = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      check("first_valid_latency", {31'd0, rd_valid}, 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_idle_timeout"}, {31'd0, busy}, 32'd0);
      check({nm, "_valid_after"}, {31'd0, rd_valid}, 32'd0);
      check({nm, "_bytes_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic read_lane(input logic [1:0] ln, input logic [15:0] exp, input string nm);
      start_read(ln, exp, 1'b1);
      wait_idle(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // {we, lane, mode, seed, run steps, read lane, expected lane value}
      vt[0]  = '{1'b0, 2'd0, 2'd0, 8'h00, 3, 2'd2, 16'h000B};
      vt[1]  = '{1'b1, 2'd1, 2'd2, 8'h81, 0, 2'd1, 16'h8181};
      vt[2]  = '{1'b0, 2'd0, 2'd0, 8'h00, 1, 2'd1, 16'h0302};
      vt[3]  = '{1'b1, 2'd3, 2'd1, 8'hFF, 1, 2'd3, 16'h0003};
      vt[4]  = '{1'b1, 2'd2, 2'd0, 8'h5A, 2, 2'd2, 16'h5A5A};
      vt[5]  = '{1'b0, 2'd0, 2'd0, 8'h00, 0, 2'd1, 16'h1810};
      vt[6]  = '{1'b1, 2'd0, 2'd3, 8'h00, 1, 2'd0, 16'h0001};
      vt[7]  = '{1'b0, 2'd0, 2'd0, 8'h00, 1, 2'd0, 16'h0002};
      vt[8]  = '{1'b0, 2'd0, 2'd0, 8'h00, 1, 2'd0, 16'h0007};
      vt[9]  = '{1'b0, 2'd0, 2'd0, 8'h00, 1, 2'd1, 16'h8101};
      vt[10] = '{1'b0, 2'd0, 2'd0, 8'h00, 0, 2'd3, 16'h001B};
      vt[11] = '{1'b0, 2'd0, 2'd0, 8'h00, 0, 2'd2, 16'h5A5A};

      rst = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_lane = '0; cfg_mode = '0;
      cfg_seed = '0; rd_req = 1'b0; rd_lane = '0; rd_ready = 1'b1;
      do_reset();

      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_rd_last", {31'd0, rd_last}, 32'd0);
      check("reset_rd_data", {24'd0, rd_data}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         if (vt[i].we) cycle(1'b0, 1'b1, vt[i].lane, vt[i].mode, vt[i].seed);
         repeat (vt[i].nrun) cycle(1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
         read_lane(vt[i].rd, vt[i].exp, $sformatf("vec%0d", i));
      end

      // Stall with ready low; a request inside the window must be ignored.
      rd_ready = 1'b0;
      start_read(2'd3, 16'h001B, 1'b1);
      for (int k = 0; k < 5; k++) begin
         rd_lane = 2'd1;
         rd_req  = (k == 1);
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_valid", k), {31'd0, rd_valid}, 32'd1);
         check($sformatf("stall%0d_data", k), {24'd0, rd_data}, 32'h1B);
         check($sformatf("stall%0d_last", k), {31'd0, rd_last}, 32'd0);
      end
      rd_req   = 1'b0;
      rd_ready = 1'b1;
      wait_idle("stall");

      // Load and step on the same cycle: the loaded lane does not step.
      do_reset();
      cycle(1'b1, 1'b1, 2'd0, 2'd3, 8'h10);
      read_lane(2'd0, 16'h1010, "same_cycle_lane0");
      read_lane(2'd1, 16'h0003, "same_cycle_lane1");

      // Reset during the first SEND cycle aborts the transfer.
      rd_ready = 1'b0;
      start_read(2'd2, 16'h0000, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_valid", {31'd0, rd_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_last", {31'd0, rd_last}, 32'd0);
      check("abort_data", {24'd0, rd_data}, 32'd0);
`ifdef SEXY_GRID_SIGNATURE_EN
      check("abort_sig", {16'd0, sig}, 32'd0);
`endif
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         read_lane(2'(i), 16'(i), $sformatf("post_abort_lane%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
